transmissor_telemetria_drone: RTL and testbench

Serial telemetry stage downstream of the drone simulator. It watches the simulator's debug/result outputs (position, obstacles, collision count, win/lose) and, whenever that snapshot changes or a send is forced, transmits a fixed 6-byte ASCII frame over a UART 8N1 line to the host PC. Only the most recent snapshot is ever sent; intermediate values that appear during a transmission are dropped.

---
 rtl/transmissor_telemetria_drone.sv | 199 +++++++++++++++++++
 tb/tb_transmissor_telemetria_drone.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_telemetria_drone.sv
// Telemetry UART transmitter: sends a 6-byte ASCII snapshot frame of the drone
// simulator state (8N1, LSB first) whenever the snapshot changes or a send is forced.
module transmissor_telemetria_drone #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [3:0] posicao_horizontal,
  input  logic [3:0] posicao_vertical,
  input  logic [3:0] obstaculos,
  input  logic [2:0] colisoes,
  input  logic       venceu,
  input  logic       perdeu,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       fim_envio,
  output logic [3:0] db_estado
);

  localparam int unsigned SNAP_W    = 17;
  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST_BYTE = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CARREGA = 4'd1,
    START   = 4'd2,
    DADOS   = 4'd3,
    STOP    = 4'd4,
    PROXIMO = 4'd5,
    FIM     = 4'd6
  } estado_t;

  estado_t           state_q, state_d;
  logic [SNAP_W-1:0] frame_q, frame_d;
  logic [SNAP_W-1:0] ultimo_q, ultimo_d;
  logic              pendente_q, pendente_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic              saida_q, saida_d;
  logic              ocupado_q, ocupado_d;
  logic              fim_q, fim_d;

  logic [SNAP_W-1:0] snapshot;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_nxt;
  logic              cnt_done;

  // Nibble to uppercase hex ASCII character
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign snapshot = {posicao_horizontal, posicao_vertical, obstaculos,
                     colisoes, venceu, perdeu};
  assign bit_nxt  = bit_idx_q + 3'd1;
  assign cnt_done = (cnt_q == CNT_LAST);

  // Select the character currently being shifted from the latched frame
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q)
      3'd0: cur_byte = hex_ascii(frame_q[16:13]);
      3'd1: cur_byte = hex_ascii(frame_q[12:9]);
      3'd2: cur_byte = hex_ascii(frame_q[8:5]);
      3'd3: cur_byte = 8'h30 + {5'b0, frame_q[4:2]};
      3'd4: begin
        if (frame_q[0])      cur_byte = 8'h50;
        else if (frame_q[1]) cur_byte = 8'h56;
        else                 cur_byte = 8'h4A;
      end
      default: cur_byte = 8'h0A;
    endcase
  end

  // Next-state and next-output logic; line level is computed for the next state
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    ultimo_d   = ultimo_q;
    pendente_d = pendente_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    saida_d    = saida_q;

    case (state_q)
      IDLE: begin
        saida_d = 1'b1;
        if (pendente_q || enviar || (snapshot != ultimo_q)) state_d = CARREGA;
      end
      CARREGA: begin
        frame_d    = snapshot;
        ultimo_d   = snapshot;
        pendente_d = 1'b0;
        byte_idx_d = 3'd0;
        bit_idx_d  = 3'd0;
        cnt_d      = '0;
        state_d    = START;
        saida_d    = 1'b0;
      end
      START: begin
        if (cnt_done) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DADOS;
          saida_d   = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DADOS: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            saida_d = 1'b1;
          end else begin
            bit_idx_d = bit_nxt;
            saida_d   = cur_byte[bit_nxt];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = PROXIMO;
          saida_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PROXIMO: begin
        if (byte_idx_q == 3'(LAST_BYTE)) begin
          state_d = FIM;
          saida_d = 1'b1;
        end else begin
          byte_idx_d = byte_idx_q + 3'd1;
          state_d    = START;
          saida_d    = 1'b0;
        end
      end
      FIM: begin
        state_d = IDLE;
        saida_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        saida_d = 1'b1;
      end
    endcase
  end

  // Status outputs follow the next state so they are aligned with db_estado
  always_comb begin
    ocupado_d = (state_d != IDLE);
    fim_d     = (state_d == FIM);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      ultimo_q   <= '0;
      pendente_q <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      saida_q    <= 1'b1;
      ocupado_q  <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      ultimo_q   <= ultimo_d;
      pendente_q <= pendente_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      saida_q    <= saida_d;
      ocupado_q  <= ocupado_d;
      fim_q      <= fim_d;
    end
  end

  assign saida_serial = saida_q;
  assign ocupado      = ocupado_q;
  assign fim_envio    = fim_q;
  assign db_estado    = 4'(state_q);

endmodule

// File: tb/tb_transmissor_telemetria_drone.sv
// Directed bench for the telemetry UART transmitter (CLKS_PER_BIT = 4).
module tb_transmissor_telemetria_drone;

  localparam int unsigned CPB = 4;

  logic       clock;
  logic       reset;
  logic       enviar;
  logic [3:0] posicao_horizontal;
  logic [3:0] posicao_vertical;
  logic [3:0] obstaculos;
  logic [2:0] colisoes;
  logic       venceu;
  logic       perdeu;
  logic       saida_serial;
  logic       ocupado;
  logic       fim_envio;
  logic [3:0] db_estado;

  int checks = 0;
  int fails  = 0;
  int busy_run = 0;
  int last_len = 0;
  int fim_count = 0;

  transmissor_telemetria_drone #(.CLKS_PER_BIT(CPB)) dut (
    .clock              (clock),
    .reset              (reset),
    .enviar             (enviar),
    .posicao_horizontal (posicao_horizontal),
    .posicao_vertical   (posicao_vertical),
    .obstaculos         (obstaculos),
    .colisoes           (colisoes),
    .venceu             (venceu),
    .perdeu             (perdeu),
    .saida_serial       (saida_serial),
    .ocupado            (ocupado),
    .fim_envio          (fim_envio),
    .db_estado          (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame length (busy cycles) and completion pulse monitor
  always @(negedge clock) begin
    if (!reset) begin
      busy_run = 0;
    end else if (ocupado === 1'b1) begin
      busy_run = busy_run + 1;
    end else if (busy_run != 0) begin
      last_len = busy_run;
      busy_run = 0;
    end
    if (fim_envio === 1'b1) fim_count = fim_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      if (saida_serial === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic sample_byte(output logic [7:0] b, output logic stop);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clock);
      b[i] = saida_serial;
    end
    repeat (CPB) @(negedge clock);
    stop = saida_serial;
  endtask

  // Receive a 6-byte frame; optionally change posicao_horizontal right after
  // the start bit of byte cb1 / cb2 is seen.
  task automatic recv_frame(input string tag, input logic [47:0] exp,
                            input int cb1, input logic [3:0] h1,
                            input int cb2, input logic [3:0] h2);
    logic ok;
    logic [7:0] b;
    logic stop;
    for (int k = 0; k < 6; k++) begin
      wait_start(tag, ok);
      if (!ok) return;
      if (k == cb1) posicao_horizontal = h1;
      if (k == cb2) posicao_horizontal = h2;
      sample_byte(b, stop);
      chk($sformatf("%s_byte%0d", tag, k), 32'(b), 32'(exp[47-8*k -: 8]));
      chk($sformatf("%s_stop%0d", tag, k), 32'(stop), 32'd1);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (ocupado === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    @(negedge clock);
  endtask

  initial begin
    logic ok;
    int   low_seen;
    int   busy_seen;
    int   fim_base;
    int   gap;

    enviar             = 1'b0;
    posicao_horizontal = 4'h3;
    posicao_vertical   = 4'hA;
    obstaculos         = 4'h0;
    colisoes           = 3'd2;
    venceu             = 1'b0;
    perdeu             = 1'b0;
    reset              = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_saida", 32'(saida_serial), 32'd1);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_fim", 32'(fim_envio), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);

    // First frame after reset is sent because of the pending flag
    reset = 1'b1;
    @(negedge clock);
    chk("first_carrega", 32'(db_estado), 32'd1);
    chk("first_carrega_line", 32'(saida_serial), 32'd1);
    chk("first_carrega_busy", 32'(ocupado), 32'd1);
    @(negedge clock);
    chk("first_start_line", 32'(saida_serial), 32'd0);
    chk("first_start_estado", 32'(db_estado), 32'd2);
    recv_frame("f1", 48'h3341_3032_4A0A, -1, 4'h0, -1, 4'h0);
    wait_idle("f1");
    chk("f1_len", 32'(last_len), 32'd248);
    chk("f1_fim", 32'(fim_count), 32'd1);
    chk("f1_idle_line", 32'(saida_serial), 32'd1);

    // Constant inputs: nothing is sent
    low_seen  = 0;
    busy_seen = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1) low_seen++;
      if (ocupado !== 1'b0) busy_seen++;
    end
    chk("quiet_line", 32'(low_seen), 32'd0);
    chk("quiet_busy", 32'(busy_seen), 32'd0);

    // Forced frame; H changes during bytes 1 and 3, only the last value follows
    fim_base = fim_count;
    enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
    recv_frame("f2", 48'h3341_3032_4A0A, 1, 4'h4, 3, 4'h5);
    recv_frame("f3", 48'h3541_3032_4A0A, -1, 4'h0, -1, 4'h0);
    wait_idle("f3");
    low_seen = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1) low_seen++;
    end
    chk("f3_no_more", 32'(low_seen), 32'd0);
    chk("f3_fim_twice", 32'(fim_count - fim_base), 32'd2);

    // Lose has priority over win
    venceu = 1'b1;
    perdeu = 1'b1;
    recv_frame("f4", 48'h3541_3032_500A, -1, 4'h0, -1, 4'h0);
    wait_idle("f4");
    chk("f4_len", 32'(last_len), 32'd248);

    // enviar held high: back-to-back identical frames with one idle cycle
    enviar = 1'b1;
    recv_frame("f5", 48'h3541_3032_500A, -1, 4'h0, -1, 4'h0);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (ocupado === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("f5_reach_idle", 32'(ok), 32'd1);
    gap = 0;
    for (int n = 0; n < 20; n++) begin
      if (ocupado !== 1'b0) break;
      gap++;
      @(negedge clock);
    end
    chk("f5_gap", 32'(gap), 32'd1);
    chk("f5_recarga", 32'(db_estado), 32'd1);
    recv_frame("f6", 48'h3541_3032_500A, -1, 4'h0, -1, 4'h0);
    enviar = 1'b0;
    wait_idle("f6");

    // Reset during DADOS of byte 2, then a complete fresh frame
    enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_start("f7", ok);
      if (k < 2) repeat (10 * CPB - 2) @(negedge clock);
    end
    repeat (6) @(negedge clock);
    chk("f7_in_dados", 32'(db_estado), 32'd3);
    chk("f7_line_low", 32'(saida_serial), 32'd0);
    reset = 1'b0;
    #1;
    chk("f7_rst_line", 32'(saida_serial), 32'd1);
    chk("f7_rst_estado", 32'(db_estado), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    recv_frame("f8", 48'h3541_3032_500A, -1, 4'h0, -1, 4'h0);
    wait_idle("f8");
    chk("f8_len", 32'(last_len), 32'd248);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
